// File: rtl/ysyx_23060111_lsu.sv
// Load/store stage: one op in flight, one 32-bit valid/ready bus transaction,
// load alignment/extension and write-back hand-off to the WBU.
module ysyx_23060111_lsu #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_is_load,
   input  logic        in_is_store,
   input  logic [2:0]  in_funct3,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [4:0]  in_rd,
   input  logic        in_wen,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_resp_valid,
   output logic        mem_resp_ready,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [4:0]  out_rd,
   output logic        out_wen,
   output logic        out_err
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   logic [1:0]    state_q, state_d;
   logic          ld_q, ld_d;
   logic          st_q, st_d;
   logic [2:0]    f3_q, f3_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wd_q, wd_d;
   logic [31:0]   data_q, data_d;
   logic [4:0]    rd_q, rd_d;
   logic          wen_q, wen_d;
   logic          err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          is_h, is_w, misal, illegal;
   logic [31:0]   sh, ld_val;

   assign is_h    = in_funct3[1:0] == 2'b01;
   assign is_w    = in_funct3[1:0] == 2'b10;
   assign misal   = (is_h & in_addr[0]) | (is_w & (|in_addr[1:0]));
   assign illegal = (in_is_load & ((in_funct3 == 3'b011) | (in_funct3[2:1] == 2'b11)))
                  | (in_is_store & (in_funct3[2] | (in_funct3[1:0] == 2'b11)));

   assign sh = mem_rdata >> {addr_q[1:0], 3'b000};

   always_comb begin
      case (f3_q)
         3'b000:  ld_val = {{24{sh[7]}}, sh[7:0]};
         3'b001:  ld_val = {{16{sh[15]}}, sh[15:0]};
         3'b100:  ld_val = {24'd0, sh[7:0]};
         3'b101:  ld_val = {16'd0, sh[15:0]};
         default: ld_val = sh;
      endcase
   end

   // Store lanes are replicated so the strobes alone select the bytes.
   always_comb begin
      case (f3_q[1:0])
         2'b00: begin
            mem_wdata = {4{wd_q[7:0]}};
            mem_wstrb = 4'b0001 << addr_q[1:0];
         end
         2'b01: begin
            mem_wdata = {2{wd_q[15:0]}};
            mem_wstrb = 4'b0011 << addr_q[1:0];
         end
         default: begin
            mem_wdata = wd_q;
            mem_wstrb = 4'hF;
         end
      endcase
      if (!st_q) mem_wstrb = 4'h0;
   end

   assign in_ready       = state_q == IDLE;
   assign mem_req_valid  = state_q == REQ;
   assign mem_resp_ready = state_q == WAIT;
   assign out_valid      = state_q == RESP;
   assign mem_we         = st_q;
   assign mem_addr       = {addr_q[31:2], 2'b00};
   assign out_data       = data_q;
   assign out_rd         = rd_q;
   assign out_wen        = wen_q;
   assign out_err        = err_q;

   always_comb begin
      state_d = state_q;
      ld_d    = ld_q;
      st_d    = st_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wd_d    = wd_q;
      data_d  = data_q;
      rd_d    = rd_q;
      wen_d   = wen_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (in_valid) begin
            ld_d   = in_is_load;
            st_d   = in_is_store;
            f3_d   = in_funct3;
            addr_d = in_addr;
            wd_d   = in_wdata;
            rd_d   = in_rd;
            if (!in_is_load && !in_is_store) begin
               data_d  = in_addr;
               wen_d   = in_wen;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (misal || illegal) begin
               data_d  = 32'd0;
               wen_d   = 1'b0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               err_d   = 1'b0;
               state_d = REQ;
            end
         end
         REQ: if (mem_req_ready) begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // A response in the timeout cycle still completes normally.
            if (mem_resp_valid) begin
               data_d  = ld_q ? ld_val : 32'd0;
               wen_d   = ld_q;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (TIMEOUT != 0 && cnt_q == TMO) begin
               data_d  = 32'd0;
               wen_d   = 1'b0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: if (out_ready) state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ld_q    <= 1'b0;
         st_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= 32'd0;
         wd_q    <= 32'd0;
         data_q  <= 32'd0;
         rd_q    <= 5'd0;
         wen_q   <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ld_q    <= ld_d;
         st_q    <= st_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wd_q    <= wd_d;
         data_q  <= data_d;
         rd_q    <= rd_d;
         wen_q   <= wen_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_ysyx_23060111_lsu.sv
// Self-checking bench for the LSU: directed scenarios plus randomized ops
// against a byte-level reference model.
module tb_ysyx_23060111_lsu;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_is_load, in_is_store;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr, in_wdata;
   logic [4:0]  in_rd;
   logic        in_wen;
   logic        mem_req_valid, mem_req_ready, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_resp_valid, mem_resp_ready;
   logic [31:0] mem_rdata;
   logic        out_valid, out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_rd;
   logic        out_wen, out_err;

   int n_chk = 0;
   int n_fail = 0;

   ysyx_23060111_lsu #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_is_load(in_is_load), .in_is_store(in_is_store),
      .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
      .in_rd(in_rd), .in_wen(in_wen),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_resp_valid(mem_resp_valid),
      .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_rd(out_rd), .out_wen(out_wen), .out_err(out_err)
   );

   always #5 clk = ~clk;

   // Reference: what the op should produce, from byte-level rules.
   function automatic void ref_op(
      input bit ld, input bit st, input logic [2:0] f3,
      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
      input bit wen,
      output bit mem, output logic [31:0] d, output bit w, output bit e,
      output logic [3:0] strb, output logic [31:0] wdat);
      int sz, off;
      bit legal;
      longint v;
      sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      off = int'(a[1:0]);
      mem = 0; d = 0; w = 0; e = 0; strb = 0; wdat = 0;
      if (!ld && !st) begin
         d = a; w = wen;
         return;
      end
      legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                 : (f3 inside {3'd0, 3'd1, 3'd2});
      if (!legal || (off % sz) != 0) begin
         e = 1;
         return;
      end
      mem = 1;
      if (ld) begin
         v = 0;
         for (int i = 0; i < sz; i++)
            v = v + (longint'(rdata[8*(off+i) +: 8]) << (8*i));
         if (!f3[2] && sz < 4 && ((v >> (8*sz-1)) & 1) == 1)
            v = v - (longint'(1) << (8*sz));
         d = v[31:0];
         w = 1;
      end else begin
         for (int i = 0; i < 4; i++) begin
            strb[i] = (i >= off) && (i < off + sz);
            wdat[8*i +: 8] = wd[8*(i % sz) +: 8];
         end
      end
   endfunction

   // Runs one op end to end; entered and left just after a negedge.
   task automatic do_op(input string tag, input bit ld, input bit st,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd,
                        input bit wen, input logic [31:0] rdata,
                        input int qd, input int rdly, input int od);
      bit mem, ew, ee;
      logic [31:0] ed, ewd;
      logic [3:0] es;
      ref_op(ld, st, f3, a, wd, rdata, wen, mem, ed, ew, ee, es, ewd);
      n_chk++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s in_ready: got %b want 1", tag, in_ready);
      end
      in_valid = 1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
      in_addr = a; in_wdata = wd; in_rd = rd; in_wen = wen;
      @(negedge clk);
      in_valid = 0; in_wdata = $urandom; in_addr = $urandom;
      if (mem) begin
         for (int k = 0; k <= qd; k++) begin
            n_chk++;
            if ({mem_req_valid, mem_we, mem_addr, mem_wstrb} !==
                {1'b1, st, a[31:2], 2'b00, es}) begin
               n_fail++;
               $display("FAIL %s req[%0d]: got v=%b we=%b a=%h s=%b want v=1 we=%b a=%h s=%b",
                        tag, k, mem_req_valid, mem_we, mem_addr, mem_wstrb,
                        st, {a[31:2], 2'b00}, es);
            end
            if (st) begin
               n_chk++;
               if (mem_wdata !== ewd) begin
                  n_fail++;
                  $display("FAIL %s wdata: got %h want %h", tag, mem_wdata, ewd);
               end
            end
            if (k < qd) @(negedge clk);
         end
         mem_req_ready = 1;
         @(negedge clk);
         mem_req_ready = 0;
         for (int k = 0; k <= rdly; k++) begin
            n_chk++;
            if ({mem_req_valid, mem_resp_ready, out_valid} !== 3'b010) begin
               n_fail++;
               $display("FAIL %s wait[%0d]: got req=%b rr=%b ov=%b want 0 1 0",
                        tag, k, mem_req_valid, mem_resp_ready, out_valid);
            end
            if (k < rdly) @(negedge clk);
         end
         mem_resp_valid = 1; mem_rdata = rdata;
         @(negedge clk);
         mem_resp_valid = 0; mem_rdata = $urandom;
      end else begin
         n_chk++;
         if (mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s no_req: got %b want 0", tag, mem_req_valid);
         end
      end
      for (int k = 0; k <= od; k++) begin
         n_chk++;
         if ({out_valid, out_data, out_rd, out_wen, out_err} !==
             {1'b1, ed, rd, ew, ee}) begin
            n_fail++;
            $display("FAIL %s out[%0d]: got v=%b d=%h rd=%0d w=%b e=%b want v=1 d=%h rd=%0d w=%b e=%b",
                     tag, k, out_valid, out_data, out_rd, out_wen, out_err,
                     ed, rd, ew, ee);
         end
         if (k < od) @(negedge clk);
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      n_chk++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL %s done: got ov=%b ir=%b want 0 1", tag, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      #12;
      n_chk++;
      if ({in_ready, mem_req_valid, mem_resp_ready, out_valid, out_data,
           out_rd, out_wen, out_err, mem_wstrb} !== {4'b1000, 32'd0, 5'd0, 2'b00, 4'd0}) begin
         n_fail++;
         $display("FAIL reset: got ir=%b rq=%b rr=%b ov=%b d=%h rd=%0d w=%b e=%b s=%b",
                  in_ready, mem_req_valid, mem_resp_ready, out_valid, out_data,
                  out_rd, out_wen, out_err, mem_wstrb);
      end
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_passthrough();
      do_op("pass", 0, 0, 3'd0, 32'h1234, 32'h0, 5'd5, 1, 32'h0, 0, 0, 0);
      do_op("pass_nowen", 0, 0, 3'd2, 32'hDEAD_BEEF, 32'h0, 5'd31, 0, 32'h0, 0, 0, 2);
   endtask

   task automatic test_store();
      do_op("sb", 0, 1, 3'd0, 32'h8000_0003, 32'h0000_00A5, 5'd3, 1, 32'h0, 0, 0, 0);
      do_op("sh", 0, 1, 3'd1, 32'h8000_0002, 32'h1234_BEEF, 5'd4, 1, 32'h0, 2, 1, 1);
      do_op("sw", 0, 1, 3'd2, 32'h8000_0010, 32'hCAFE_F00D, 5'd6, 1, 32'h0, 1, 0, 0);
   endtask

   task automatic test_load_ext();
      do_op("lh", 1, 0, 3'd1, 32'h8000_0002, 32'h0, 5'd7, 0, 32'h8001_1234, 0, 0, 0);
      do_op("lhu", 1, 0, 3'd5, 32'h8000_0002, 32'h0, 5'd8, 0, 32'h8001_1234, 0, 0, 0);
      do_op("lbu", 1, 0, 3'd4, 32'h8000_0001, 32'h0, 5'd9, 0, 32'h8001_1234, 0, 0, 0);
      do_op("lb", 1, 0, 3'd0, 32'h8000_0003, 32'h0, 5'd10, 0, 32'h8001_1234, 1, 2, 0);
      do_op("lw_late", 1, 0, 3'd2, 32'h8000_0004, 32'h0, 5'd11, 0, 32'h1357_9BDF, 0, TMO, 0);
   endtask

   task automatic test_errors();
      do_op("lw_mis", 1, 0, 3'd2, 32'h8000_0002, 32'h0, 5'd12, 1, 32'h0, 0, 0, 0);
      do_op("lh_mis", 1, 0, 3'd5, 32'h8000_0001, 32'h0, 5'd13, 1, 32'h0, 0, 0, 0);
      do_op("ld_ill", 1, 0, 3'd3, 32'h8000_0000, 32'h0, 5'd14, 1, 32'h0, 0, 0, 0);
      do_op("st_ill", 0, 1, 3'd4, 32'h8000_0000, 32'h0, 5'd15, 1, 32'h0, 0, 0, 0);
   endtask

   task automatic test_timeout();
      int cnt;
      in_valid = 1; in_is_load = 1; in_is_store = 0; in_funct3 = 3'd2;
      in_addr = 32'h8000_0010; in_rd = 5'd17; in_wen = 1;
      @(negedge clk);
      in_valid = 0;
      mem_req_ready = 1;
      @(negedge clk);
      mem_req_ready = 0;
      cnt = 0;
      while (mem_resp_ready === 1'b1 && cnt < 20) begin
         cnt++;
         @(negedge clk);
      end
      n_chk++;
      if (cnt != TMO + 1) begin
         n_fail++;
         $display("FAIL tmo_cycles: got %0d want %0d", cnt, TMO + 1);
      end
      for (int k = 0; k < 4; k++) begin
         n_chk++;
         if ({out_valid, out_err, out_wen, out_data, out_rd} !==
             {3'b110, 32'd0, 5'd17}) begin
            n_fail++;
            $display("FAIL tmo_out[%0d]: got v=%b e=%b w=%b d=%h rd=%0d want 1 1 0 0 17",
                     k, out_valid, out_err, out_wen, out_data, out_rd);
         end
         @(negedge clk);
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
   endtask

   task automatic test_reset_mid();
      in_valid = 1; in_is_load = 1; in_is_store = 0; in_funct3 = 3'd2;
      in_addr = 32'h8000_0020; in_rd = 5'd18; in_wen = 1;
      @(negedge clk);
      in_valid = 0;
      mem_req_ready = 1;
      @(negedge clk);
      mem_req_ready = 0;
      rst_n = 0;
      #1;
      n_chk++;
      if ({mem_resp_ready, out_valid, mem_req_valid, in_ready} !== 4'b0001) begin
         n_fail++;
         $display("FAIL rst_mid: got rr=%b ov=%b rq=%b ir=%b want 0 0 0 1",
                  mem_resp_ready, out_valid, mem_req_valid, in_ready);
      end
      @(negedge clk);
      rst_n = 1;
      mem_resp_valid = 1; mem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      mem_resp_valid = 0;
      n_chk++;
      if ({out_valid, mem_req_valid, in_ready} !== 3'b001) begin
         n_fail++;
         $display("FAIL late_resp: got ov=%b rq=%b ir=%b want 0 0 1",
                  out_valid, mem_req_valid, in_ready);
      end
      do_op("lw_after_rst", 1, 0, 3'd2, 32'h8000_0024, 32'h0, 5'd19, 0,
            32'hCAFE_BABE, 0, 0, 0);
   endtask

   // Back-to-back random ops, including illegal/misaligned mixes.
   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         int kind;
         kind = int'($urandom_range(0, 2));
         do_op($sformatf("rnd%0d", n), kind == 1, kind == 2,
               3'($urandom_range(0, 7)), 32'($urandom), 32'($urandom),
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               32'($urandom), int'($urandom_range(0, 3)),
               int'($urandom_range(0, TMO)), int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      in_valid = 0; in_is_load = 0; in_is_store = 0; in_funct3 = 0;
      in_addr = 0; in_wdata = 0; in_rd = 0; in_wen = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0; out_ready = 0;
      test_reset();
      test_passthrough();
      test_store();
      test_load_ext();
      test_errors();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
